dst_pipe_tracker: RTL
=====================

Name: dst_pipe_tracker

Overview:
- Parametrised successor to the decode-stage write-address mux.
- Selects the destination register from the D-stage instruction word and RegDst mode.
- Carries that address and its Tnew (cycles until the result exists) through E/M/W pipeline registers.
- From the tracked state, produces the D-stage stall request and the D-stage forward selects for two source operands. Sits beside the D/E/M/W pipeline registers and replaces the hand-written A3 mux plus hazard compare logic.

Parameters:
- ADDR_W, 5, register address width.
- RT_LSB, 16, LSB of rt field in instruction word.
- RD_LSB, 11, LSB of rd field in instruction word.
- LINK_REG, 31, register written by link (jal-type) mode.
- TNEW_W, 2, width of Tnew/Tuse fields.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ir_d  in  32  D-stage instruction word.
- regdst  in  2  0 = rt, 1 = rd, 2 = LINK_REG, 3 = no write.
- tnew_d  in  TNEW_W  Tnew of the D instruction, counted from E entry.
- rs_d  in  ADDR_W  source address 1 at D.
- rt_d  in  ADDR_W  source address 2 at D.
- tuse_rs  in  TNEW_W  Tuse for rs_d.
- tuse_rt  in  TNEW_W  Tuse for rt_d.
- stall  in  1  freeze D and insert bubble into E; normally stall_req fed back by top level.
- a3_e  out  ADDR_W  E-stage destination.
- a3_m  out  ADDR_W  M-stage destination.
- a3_w  out  ADDR_W  W-stage destination.
- we_w  out  1  a3_w != 0.
- tnew_e  out  TNEW_W  E-stage Tnew.
- tnew_m  out  TNEW_W  M-stage Tnew.
- stall_req  out  1  combinational hazard stall request.
- fwd_rs  out  2  0 = regfile, 1 = from E, 2 = from M, 3 = from W.
- fwd_rt  out  2  same encoding as fwd_rs.

Behaviour:
- Decode (combinational): a3_d is chosen by regdst.
  - 0: ir_d[RT_LSB +: ADDR_W].
  - 1: ir_d[RD_LSB +: ADDR_W].
  - 2: LINK_REG.
  - 3: 0.
- A destination of 0 means "no write", whatever the mode.
- Registers: E, M and W each hold {a3, tnew}. All update on the rising clk edge when reset is high.
- E stage:
  - stall = 1: E <= {0, 0} (bubble).
  - stall = 0: E <= {a3_d, tnew_d}.
  - If a3_d == 0, tnew is stored as 0.
- M stage: M <= {a3_e, sat_dec(tnew_e)}. W stage: W <= {a3_m, sat_dec(tnew_m)}.
  - sat_dec(x) = x - 1 when x > 0, otherwise 0.
  - M and W always advance; stall never freezes them.
- W Tnew is always 0 and is not stored.
- Latency: a3_d appears on a3_e one cycle later, on a3_m two cycles later, on a3_w three cycles later.
- Stall request per source s with tuse u: hazard when s != 0 and any of:
  - a3_e == s and tnew_e > u
  - a3_m == s and tnew_m > u
- stall_req = hazard(rs_d, tuse_rs) OR hazard(rt_d, tuse_rt).
- Forward select per source s:
  - 0 if s == 0.
  - Otherwise, the nearest stage whose a3 == s. Priority E > M > W.
  - If that nearest matching stage has tnew != 0, the select is 0; older stages are not consulted.
  - Stall covers that case when needed.
  - W matches only when we_w.
- Simultaneous events: stall = 1 with a new instruction at D means the instruction stays at D (held by the external D register) and E gets a bubble. Outputs reflect pre-edge state until the edge.
- Reset (reset = 0, asynchronous): all a3 and tnew registers are cleared to 0 immediately, even mid-pipeline. The outputs then become:
  - we_w = 0
  - stall_req = 0
  - fwd_rs = 0
  - fwd_rt = 0
- Reset deassertion takes effect at the next clk edge.
- No other state; no overflow cases beyond the saturation above.

Decomposition:
- Shared package holds:
  - RegDst encodings: REGDST_RT, REGDST_RD, REGDST_LINK, REGDST_NONE.
  - Forward-select encodings: FWD_RF, FWD_E, FWD_M, FWD_W.
  - Default TNEW_W.
- One sub-module, dst_stage_reg: a single {a3, tnew} register with bubble input and saturating decrement. It is instantiated three times (E, M, W).
- The hazard compare is a function, instantiated twice (rs, rt).

Test Plan:
- Reset mid-flight: load a3 = 8, 9, 10 into E/M/W, then pull reset low between edges -> a3_e/m/w = 0, we_w = 0, stall_req = 0 immediately, before any clk edge.
- Load-use: lw, regdst = 0, rt = 8, tnew_d = 2, then add with rs_d = 8, tuse_rs = 1.
  - stall_req = 1 for exactly one cycle.
  - a3_e = 0 (bubble) while a3_m = 8, tnew_m = 1.
  - Then stall_req = 0 and fwd_rs = 0.
- Link: regdst = 2, tnew_d = 0 -> next cycle a3_e = 31; rs_d = 31, tuse_rs = 0 -> fwd_rs = 1, stall_req = 0.
- Zero register: regdst = 1 with rd = 0, tnew_d = 2 -> a3_e = 0, tnew_e = 0; rs_d = 0 -> fwd_rs = 0, stall_req = 0.
- Priority: E and M both a3 = 8 with tnew 0 -> fwd_rt = 1.
  - Set tnew_e = 1 with tuse_rt = 1 -> fwd_rt = 0, stall_req = 0.
- Mode none: regdst = 3, rt = 5 -> a3_e = 0; three cycles later we_w = 0.

Source files
------------

// File: rtl/dst_pipe_tracker_pkg.sv
// Shared encodings for the destination/hazard tracker.
package dst_pipe_tracker_pkg;

  // Default width of Tnew/Tuse fields.
  localparam int DEF_TNEW_W = 2;

  // How the D-stage destination register is chosen.
  typedef enum logic [1:0] {
    REGDST_RT   = 2'd0,
    REGDST_RD   = 2'd1,
    REGDST_LINK = 2'd2,
    REGDST_NONE = 2'd3
  } regdst_e;

  // Source of an operand at D.
  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_E  = 2'd1,
    FWD_M  = 2'd2,
    FWD_W  = 2'd3
  } fwd_e;

endpackage

// File: rtl/dst_pipe_tracker_if.sv
// Bundle of D-stage inputs and tracked-state outputs of the tracker.
interface dst_pipe_tracker_if
  import dst_pipe_tracker_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int TNEW_W = DEF_TNEW_W
);
  logic [31:0]       ir_d;
  logic [1:0]        regdst;
  logic [TNEW_W-1:0] tnew_d;
  logic [ADDR_W-1:0] rs_d;
  logic [ADDR_W-1:0] rt_d;
  logic [TNEW_W-1:0] tuse_rs;
  logic [TNEW_W-1:0] tuse_rt;
  logic              stall;
  logic [ADDR_W-1:0] a3_e;
  logic [ADDR_W-1:0] a3_m;
  logic [ADDR_W-1:0] a3_w;
  logic              we_w;
  logic [TNEW_W-1:0] tnew_e;
  logic [TNEW_W-1:0] tnew_m;
  logic              stall_req;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;

  // Pipeline control side: supplies the D-stage view, consumes hazard info.
  modport master (
    output ir_d, regdst, tnew_d, rs_d, rt_d, tuse_rs, tuse_rt, stall,
    input  a3_e, a3_m, a3_w, we_w, tnew_e, tnew_m, stall_req, fwd_rs, fwd_rt
  );

  // Tracker side.
  modport slave (
    input  ir_d, regdst, tnew_d, rs_d, rt_d, tuse_rs, tuse_rt, stall,
    output a3_e, a3_m, a3_w, we_w, tnew_e, tnew_m, stall_req, fwd_rs, fwd_rt
  );
endinterface

// File: rtl/dst_pipe_tracker_stage_reg.sv
// One pipeline slot holding {a3, tnew}; optional bubble and Tnew countdown.
module dst_stage_reg
  import dst_pipe_tracker_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int TNEW_W   = DEF_TNEW_W,
  parameter bit DEC      = 1'b0,  // count Tnew down by one on the way in
  parameter bit HAS_TNEW = 1'b1   // last stage: Tnew is known to be 0
) (
  input  logic              clk,
  input  logic              i_rst_n,
  input  logic              i_bubble,
  input  logic [ADDR_W-1:0] i_a3,
  input  logic [TNEW_W-1:0] i_tnew,
  output logic [ADDR_W-1:0] o_a3,
  output logic [TNEW_W-1:0] o_tnew
);
  logic [ADDR_W-1:0] r_a3;

  // Destination slot: a bubble loads the "no write" address.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_a3 <= '0;
    else          r_a3 <= i_bubble ? '0 : i_a3;
  end

  assign o_a3 = r_a3;

  generate
    if (HAS_TNEW) begin : g_tnew
      logic [TNEW_W-1:0] r_tnew;
      logic [TNEW_W-1:0] w_tnew_next;

      // A non-writing entry never has an outstanding result.
      always_comb begin
        w_tnew_next = '0;
        if (!i_bubble && (i_a3 != '0)) begin
          if (DEC) w_tnew_next = (i_tnew != '0) ? i_tnew - TNEW_W'(1) : '0;
          else     w_tnew_next = i_tnew;
        end
      end

      // Tnew slot.
      always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) r_tnew <= '0;
        else          r_tnew <= w_tnew_next;
      end

      assign o_tnew = r_tnew;
    end else begin : g_no_tnew
      logic w_tnew_unused;
      assign w_tnew_unused = ^i_tnew;
      assign o_tnew        = '0;
    end
  endgenerate
endmodule

// File: rtl/dst_pipe_tracker.sv
// Destination-register tracker: A3 decode, E/M/W {a3,tnew} pipeline,
// D-stage stall request and forward selects.
module dst_pipe_tracker
  import dst_pipe_tracker_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int RT_LSB   = 16,
  parameter int RD_LSB   = 11,
  parameter int LINK_REG = 31,
  parameter int TNEW_W   = DEF_TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  dst_pipe_tracker_if.slave bus
);
  logic [ADDR_W-1:0] w_a3_d, w_a3_e, w_a3_m, w_a3_w;
  logic [TNEW_W-1:0] w_tnew_e, w_tnew_m, w_tnew_w;
  logic              w_haz_rs, w_haz_rt;
  fwd_e              w_fwd_rs, w_fwd_rt;

  // Stall when a matching E/M producer will not have its result by the time
  // the consumer needs it.
  function automatic logic hazard(
    input logic [ADDR_W-1:0] s,   input logic [TNEW_W-1:0] u,
    input logic [ADDR_W-1:0] a3e, input logic [TNEW_W-1:0] te,
    input logic [ADDR_W-1:0] a3m, input logic [TNEW_W-1:0] tm
  );
    return (s != '0) && (((a3e == s) && (te > u)) || ((a3m == s) && (tm > u)));
  endfunction

  // Nearest matching stage wins; if its result is not ready yet the older
  // stages hold stale data, so fall back to the regfile (stall covers it).
  function automatic fwd_e fwd_sel(
    input logic [ADDR_W-1:0] s,
    input logic [ADDR_W-1:0] a3e, input logic [TNEW_W-1:0] te,
    input logic [ADDR_W-1:0] a3m, input logic [TNEW_W-1:0] tm,
    input logic [ADDR_W-1:0] a3w, input logic [TNEW_W-1:0] tw
  );
    if (s == '0)      return FWD_RF;
    else if (a3e == s) return (te == '0) ? FWD_E : FWD_RF;
    else if (a3m == s) return (tm == '0) ? FWD_M : FWD_RF;
    else if (a3w == s) return (tw == '0) ? FWD_W : FWD_RF;
    else               return FWD_RF;
  endfunction

  // Destination decode from the D-stage instruction word.
  always_comb begin
    w_a3_d = '0;
    case (regdst_e'(bus.regdst))
      REGDST_RT:   w_a3_d = bus.ir_d[RT_LSB +: ADDR_W];
      REGDST_RD:   w_a3_d = bus.ir_d[RD_LSB +: ADDR_W];
      REGDST_LINK: w_a3_d = ADDR_W'(LINK_REG);
      default:     w_a3_d = '0;
    endcase
  end

  dst_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b0), .HAS_TNEW(1'b1)) u_stage_e (
    .clk(clk), .i_rst_n(reset), .i_bubble(bus.stall),
    .i_a3(w_a3_d), .i_tnew(bus.tnew_d), .o_a3(w_a3_e), .o_tnew(w_tnew_e)
  );

  dst_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b1), .HAS_TNEW(1'b1)) u_stage_m (
    .clk(clk), .i_rst_n(reset), .i_bubble(1'b0),
    .i_a3(w_a3_e), .i_tnew(w_tnew_e), .o_a3(w_a3_m), .o_tnew(w_tnew_m)
  );

  dst_stage_reg #(.ADDR_W(ADDR_W), .TNEW_W(TNEW_W), .DEC(1'b1), .HAS_TNEW(1'b0)) u_stage_w (
    .clk(clk), .i_rst_n(reset), .i_bubble(1'b0),
    .i_a3(w_a3_m), .i_tnew(w_tnew_m), .o_a3(w_a3_w), .o_tnew(w_tnew_w)
  );

  assign w_haz_rs = hazard(bus.rs_d, bus.tuse_rs, w_a3_e, w_tnew_e, w_a3_m, w_tnew_m);
  assign w_haz_rt = hazard(bus.rt_d, bus.tuse_rt, w_a3_e, w_tnew_e, w_a3_m, w_tnew_m);
  assign w_fwd_rs = fwd_sel(bus.rs_d, w_a3_e, w_tnew_e, w_a3_m, w_tnew_m, w_a3_w, w_tnew_w);
  assign w_fwd_rt = fwd_sel(bus.rt_d, w_a3_e, w_tnew_e, w_a3_m, w_tnew_m, w_a3_w, w_tnew_w);

  assign bus.a3_e      = w_a3_e;
  assign bus.a3_m      = w_a3_m;
  assign bus.a3_w      = w_a3_w;
  assign bus.we_w      = (w_a3_w != '0);
  assign bus.tnew_e    = w_tnew_e;
  assign bus.tnew_m    = w_tnew_m;
  assign bus.stall_req = w_haz_rs | w_haz_rt;
  assign bus.fwd_rs    = w_fwd_rs;
  assign bus.fwd_rt    = w_fwd_rt;
endmodule
